// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer_pkg
// Purpose : Shared types and constants for the PC sequencer: the 1-bit
//           sequencer state encoding, the sequential PC increment and a
//           word-alignment helper for redirect targets.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package pc_sequencer_pkg;

    // RUN: no redirect pending.  PEND: a redirect target is held until fetch unstalls.
    typedef enum logic [0:0] {
        PCS_RUN  = 1'b0,
        PCS_PEND = 1'b1
    } pcs_state_e;

    localparam logic [31:0] c_PC_INC = 32'd4;

    // Instruction fetch addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer_sat_counter
// Purpose : W-bit up counter that increments on i_en and sticks at all-ones
//           instead of wrapping. Synchronous clear.
// Ports   : clk      in  1  clock, rising edge
//           i_clear  in  1  synchronous clear to zero
//           i_en     in  1  count enable
//           o_count  out W  current count
// Revision: 1.0  initial release
// ============================================================================
module pc_sequencer_sat_counter
    import pc_sequencer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] c_ONE = W'(1);

    logic [W-1:0] r_count_q;
    logic [W-1:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_en && (r_count_q != '1)) begin
            w_count_d = r_count_q + c_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;

endmodule : pc_sequencer_sat_counter
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Owns the fetch PC. Resolves EX-stage branches/jumps using the
//           quick-compare result, redirects fetch (deferring the redirect
//           while fetch is stalled), squashes wrong-path instructions and
//           keeps saturating taken / not-taken branch counters.
// Ports   : phi1        in  1      clock, rising edge
//           reset       in  1      synchronous, active-high
//           FetchStall  in  1      fetch stalled; PC holds
//           BrValid     in  1      conditional branch in EX
//           BrResult    in  1      branch taken
//           BrTarget    in  32     branch target
//           JmpValid    in  1      jump in EX
//           JmpTarget   in  32     jump target
//           ExcValid    in  1      exception committed
//           BrLikely    in  1      branch-likely (only with PCSEQ_BRLIKELY_EN)
//           PC          out 32     fetch address
//           SquashIF    out 1      kill instruction entering ID
//           SquashID    out 1      kill instruction entering EX
//           TakenCnt    out CNT_W  taken-branch count
//           NTakenCnt   out CNT_W  not-taken-branch count
// Config  : PCSEQ_BRLIKELY_EN  adds BrLikely; an untaken branch-likely
//           annuls its delay slot through SquashID.
// Revision: 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0080,
    parameter int          CNT_W      = 16
) (
    input  logic             phi1,
    input  logic             reset,
    input  logic             FetchStall,
    input  logic             BrValid,
    input  logic             BrResult,
    input  logic [31:0]      BrTarget,
    input  logic             JmpValid,
    input  logic [31:0]      JmpTarget,
    input  logic             ExcValid,
`ifdef PCSEQ_BRLIKELY_EN
    input  logic             BrLikely,
`endif
    output logic [31:0]      PC,
    output logic             SquashIF,
    output logic             SquashID,
    output logic [CNT_W-1:0] TakenCnt,
    output logic [CNT_W-1:0] NTakenCnt
);

    pcs_state_e  r_state_q, w_state_d;
    logic [31:0] r_pc_q,    w_pc_d;
    logic [31:0] r_pend_q,  w_pend_d;
    logic        r_sqif_q,  w_sqif_d;
    logic        r_sqid_q,  w_sqid_d;

    logic        w_req;
    logic [31:0] w_tgt;
    logic        w_annul;

    // A branch in EX selects its own target even when a jump is also flagged.
    assign w_req = (BrValid & BrResult) | JmpValid;
    assign w_tgt = align_word(BrValid ? BrTarget : JmpTarget);

`ifdef PCSEQ_BRLIKELY_EN
    assign w_annul = BrValid & BrLikely & ~BrResult;
`else
    assign w_annul = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_pend_d  = r_pend_q;
        w_sqif_d  = 1'b0;
        w_sqid_d  = w_annul;

        if (ExcValid) begin
            // Exception overrides everything, including a held redirect and the stall.
            w_pc_d    = EXC_VECTOR;
            w_state_d = PCS_RUN;
            w_pend_d  = '0;
            w_sqif_d  = 1'b1;
            w_sqid_d  = 1'b1;
        end else if (r_state_q == PCS_PEND) begin
            // While a redirect is held, later requests are ignored: the first one wins.
            if (!FetchStall) begin
                w_pc_d    = r_pend_q;
                w_state_d = PCS_RUN;
                w_pend_d  = '0;
                w_sqif_d  = 1'b1;
            end
        end else if (w_req) begin
            if (FetchStall) begin
                w_pend_d  = w_tgt;
                w_state_d = PCS_PEND;
            end else begin
                w_pc_d   = w_tgt;
                w_sqif_d = 1'b1;
            end
        end else if (!FetchStall) begin
            w_pc_d = r_pc_q + c_PC_INC;
        end
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            r_state_q <= PCS_RUN;
            r_pc_q    <= RESET_PC;
            r_pend_q  <= '0;
            r_sqif_q  <= 1'b0;
            r_sqid_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_pend_q  <= w_pend_d;
            r_sqif_q  <= w_sqif_d;
            r_sqid_q  <= w_sqid_d;
        end
    end

    // Branch statistics count every resolved branch, whatever the stall or state.
    pc_sequencer_sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk     (phi1),
        .i_clear (reset),
        .i_en    (BrValid & BrResult),
        .o_count (TakenCnt)
    );

    pc_sequencer_sat_counter #(.W(CNT_W)) u_ntaken_cnt (
        .clk     (phi1),
        .i_clear (reset),
        .i_en    (BrValid & ~BrResult),
        .o_count (NTakenCnt)
    );

    assign PC       = r_pc_q;
    assign SquashIF = r_sqif_q;
    assign SquashID = r_sqid_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Self-checking bench for pc_sequencer: directed vector table,
//           hand sequences for stall/pending/exception/saturation/wrap cases,
//           then randomized stimulus against a queue-based reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int          TB_CNT_W = 4;
    localparam int          CMAX     = (1 << TB_CNT_W) - 1;
    localparam logic [31:0] RST_PC   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_PC   = 32'h8000_0080;

    logic        phi1 = 1'b0;
    logic        reset, fs, bv, br, jv, ev, bl;
    logic [31:0] bt, jt;
    logic [31:0] PC;
    logic        SquashIF, SquashID;
    logic [TB_CNT_W-1:0] TakenCnt, NTakenCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 phi1 = ~phi1;

    pc_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .phi1       (phi1),
        .reset      (reset),
        .FetchStall (fs),
        .BrValid    (bv),
        .BrResult   (br),
        .BrTarget   (bt),
        .JmpValid   (jv),
        .JmpTarget  (jt),
        .ExcValid   (ev),
`ifdef PCSEQ_BRLIKELY_EN
        .BrLikely   (bl),
`endif
        .PC         (PC),
        .SquashIF   (SquashIF),
        .SquashID   (SquashID),
        .TakenCnt   (TakenCnt),
        .NTakenCnt  (NTakenCnt)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic [31:0] m_q[$];   // held redirect targets (at most one is ever kept)
    logic        m_sqif, m_sqid;
    int          m_tc, m_ntc;

    task automatic model_edge();
        logic        req;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = RST_PC; m_q.delete(); m_sqif = 0; m_sqid = 0; m_tc = 0; m_ntc = 0;
            return;
        end
        if (bv) begin
            if (br) begin if (m_tc < CMAX) m_tc++; end
            else    begin if (m_ntc < CMAX) m_ntc++; end
        end
        m_sqif = 0;
        m_sqid = 0;
        req = (bv && br) || jv;
        tgt = (bv ? bt : jt);
        tgt[1:0] = 2'b00;
        if (ev) begin
            m_pc = EXC_PC; m_q.delete(); m_sqif = 1; m_sqid = 1;
        end else if (m_q.size() > 0) begin
            if (!fs) begin m_pc = m_q.pop_front(); m_sqif = 1; end
        end else if (req) begin
            if (fs) m_q.push_back(tgt);
            else begin m_pc = tgt; m_sqif = 1; end
        end else if (!fs) begin
            m_pc = m_pc + 32'd4;
        end
`ifdef PCSEQ_BRLIKELY_EN
        if (bv && bl && !br) m_sqid = 1;
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge phi1);
        #1;
    endtask

    task automatic idle();
        fs = 0; bv = 0; br = 0; bt = '0; jv = 0; jt = '0; ev = 0; bl = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic e_if,
                           input logic e_id, input int e_tc, input int e_ntc);
        chk({nm, ".PC"},        PC,               e_pc);
        chk({nm, ".SquashIF"},  {31'b0, SquashIF}, {31'b0, e_if});
        chk({nm, ".SquashID"},  {31'b0, SquashID}, {31'b0, e_id});
        chk({nm, ".TakenCnt"},  32'(TakenCnt),     32'(e_tc));
        chk({nm, ".NTakenCnt"}, 32'(NTakenCnt),    32'(e_ntc));
    endtask

    typedef struct {
        logic        fs, bv, br;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        ev;
        logic [31:0] e_pc;
        logic        e_if, e_id;
        int          e_tc, e_ntc;
    } vec_t;

    vec_t vt[10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'hBFC0_0004,1'b0,1'b0,0,0};
        vt[1] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'hBFC0_0008,1'b0,1'b0,0,0};
        vt[2] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'hBFC0_000C,1'b0,1'b0,0,0};
        vt[3] = '{1'b0,1'b0,1'b0,32'h0,1'b1,32'h0000_1000,1'b0, 32'h0000_1000,1'b1,1'b0,0,0};
        vt[4] = '{1'b0,1'b1,1'b1,32'h0040_0103,1'b0,32'h0,1'b0, 32'h0040_0100,1'b1,1'b0,1,0};
        vt[5] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h0040_0104,1'b0,1'b0,1,0};
        vt[6] = '{1'b0,1'b1,1'b0,32'h0000_9999,1'b0,32'h0,1'b0, 32'h0040_0108,1'b0,1'b0,1,1};
        vt[7] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0, 32'h0040_0108,1'b0,1'b0,1,1};
        vt[8] = '{1'b0,1'b1,1'b1,32'h0000_4002,1'b1,32'h0000_6000,1'b0, 32'h0000_4000,1'b1,1'b0,2,1};
        vt[9] = '{1'b0,1'b0,1'b0,32'h0,1'b1,32'h0000_700F,1'b0, 32'h0000_700C,1'b1,1'b0,2,1};

        // ---- reset state ----
        idle(); reset = 1;
        step();
        chk_all("reset", RST_PC, 0, 0, 0, 0);
        reset = 0;

        // ---- directed vector table ----
        for (int i = 0; i < 10; i++) begin
            idle();
            fs = vt[i].fs; bv = vt[i].bv; br = vt[i].br; bt = vt[i].bt;
            jv = vt[i].jv; jt = vt[i].jt; ev = vt[i].ev;
            step();
            chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_if, vt[i].e_id,
                    vt[i].e_tc, vt[i].e_ntc);
        end

        // ---- stalled taken branch, second branch during PEND ignored ----
        idle(); reset = 1; step(); reset = 0;
        chk_all("t3_reset", RST_PC, 0, 0, 0, 0);
        idle(); fs = 1; bv = 1; br = 1; bt = 32'h0000_2000; step();
        chk_all("t3_a", RST_PC, 0, 0, 1, 0);
        idle(); fs = 1; bv = 1; br = 1; bt = 32'h0000_3000; step();
        chk_all("t3_b", RST_PC, 0, 0, 2, 0);
        idle(); fs = 1; step();
        chk_all("t3_c", RST_PC, 0, 0, 2, 0);
        idle(); step();
        chk_all("t3_d", 32'h0000_2000, 1, 0, 2, 0);
        idle(); step();
        chk_all("t3_e", 32'h0000_2004, 0, 0, 2, 0);

        // ---- exception during PEND drops the held redirect; branch still counted ----
        idle(); fs = 1; bv = 1; br = 1; bt = 32'h0000_5000; step();
        chk_all("t4_a", 32'h0000_2004, 0, 0, 3, 0);
        idle(); fs = 1; ev = 1; bv = 1; br = 0; step();
        chk_all("t4_b", EXC_PC, 1, 1, 3, 1);
        idle(); fs = 1; step();
        chk_all("t4_c", EXC_PC, 0, 0, 3, 1);
        idle(); step();
        chk_all("t4_d", 32'h8000_0084, 0, 0, 3, 1);

        // ---- reset while a redirect is pending discards it ----
        idle(); fs = 1; jv = 1; jt = 32'h0000_7000; step();
        chk_all("rp_a", 32'h8000_0084, 0, 0, 3, 1);
        idle(); fs = 1; reset = 1; step(); reset = 0;
        chk_all("rp_b", RST_PC, 0, 0, 0, 0);
        idle(); step();
        chk_all("rp_c", 32'hBFC0_0004, 0, 0, 0, 0);

        // ---- not-taken counter saturation, then PC wrap ----
        for (int i = 0; i < 20; i++) begin
            idle(); bv = 1; br = 0; bt = 32'h1234_5678; step();
            chk_all($sformatf("t5_nt%0d", i), 32'hBFC0_0004 + 32'(4 * (i + 1)), 0, 0, 0,
                    (i + 1 < CMAX) ? i + 1 : CMAX);
        end
        idle(); jv = 1; jt = 32'hFFFF_FFFF; step();
        chk_all("t5_jmp", 32'hFFFF_FFFC, 1, 0, 0, CMAX);
        idle(); step();
        chk_all("t5_wrap", 32'h0000_0000, 0, 0, 0, CMAX);

        // ---- branch-likely not taken ----
        idle(); bv = 1; bl = 1; br = 0; bt = 32'h0000_1234; step();
`ifdef PCSEQ_BRLIKELY_EN
        chk_all("t6_annul", 32'h0000_0004, 0, 1, 0, CMAX);
`else
        chk_all("t6_annul", 32'h0000_0004, 0, 0, 0, CMAX);
`endif
        idle(); step();
        chk_all("t6_after", 32'h0000_0008, 0, 0, 0, CMAX);

        // ---- randomized against the reference model ----
        for (int i = 0; i < 400; i++) begin
            idle();
            reset = ($urandom_range(0, 49) == 0);
            fs    = ($urandom_range(0, 2) == 0);
            bv    = ($urandom_range(0, 3) == 0);
            br    = 1'($urandom_range(0, 1));
            bt    = $urandom;
            jv    = !(bv && !br) && ($urandom_range(0, 5) == 0);
            jt    = $urandom;
            ev    = ($urandom_range(0, 19) == 0);
            bl    = 1'($urandom_range(0, 1));
            step();
            chk_all("rand", m_pc, m_sqif, m_sqid, m_tc, m_ntc);
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
